// File: rtl/fetch_buffer.sv
// Fetch stage: owns the PC, issues 1-cycle-latency instruction memory reads and
// queues {pc, instr} pairs for Decode behind a credit-checked FIFO.
module fetch_buffer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q;
  logic          inflight_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0][31:0] entry_pc;
  logic [DEPTH-1:0][31:0] entry_instr;

  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;

  // Credits cover both stored entries and the response still on its way back,
  // so a push can never find the FIFO full.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign imem_req    = !reset && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_addr   = pc_q;

  assign push        = inflight_q && !redirect_valid;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && dec_ready;

  assign instruction = instr_valid ? entry_instr[rd_ptr_q] : 32'h0000_0000;
  assign instr_pc    = instr_valid ? entry_pc[rd_ptr_q]    : 32'h0000_0000;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [31:0] pc_slot_q;
    logic [31:0] instr_slot_q;

    always_ff @(posedge clk) begin
      if (!reset && push && (wr_ptr_q == PW'(gi))) begin
        pc_slot_q    <= req_pc_q;
        instr_slot_q <= imem_rdata;
      end
    end

    assign entry_pc[gi]    = pc_slot_q;
    assign entry_instr[gi] = instr_slot_q;
  end

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      // Flush wins over any same-cycle pop or arriving response.
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req) pc_d = pc_q + 32'd4;
      if (push)     wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      req_pc_q   <= PC_RESET;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (imem_req) req_pc_q <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a 1-cycle memory returning addr ^ 0x13,
// with hand-computed expectations for each scenario.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        dec_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] req_log[$];
  logic [31:0] dec_pc_log[$];
  logic [31:0] dec_instr_log[$];

  fetch_buffer #(
    .PC_RESET(32'h0000_0000),
    .DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_ready     (dec_ready),
    .instr_valid   (instr_valid),
    .instruction   (instruction),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ 32'h0000_0013) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (imem_req) req_log.push_back(imem_addr);
    if (instr_valid && dec_ready) begin
      dec_pc_log.push_back(instr_pc);
      dec_instr_log.push_back(instruction);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, instruction, 32'h0);
    check({tag, "_pc"}, instr_pc, 32'h0);
  endtask

  logic [31:0] wrap_pc[4];
  logic [31:0] wrap_ins[4];

  initial begin
    wrap_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    wrap_ins = '{32'hFFFF_FFEB, 32'hFFFF_FFEF, 32'h0000_0013, 32'h0000_0017};

    // Reset held 3 cycles with redirect and dec_ready asserted.
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst%0d_req", i), 32'(imem_req), 32'd0);
      check($sformatf("rst%0d_addr", i), imem_addr, 32'h0);
      check_empty($sformatf("rst%0d", i));
    end

    // Stream: C0 in this cycle.
    reset = 1'b0; redirect_valid = 1'b0;
    #1;
    check("c0_req", 32'(imem_req), 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    check("c0_valid", 32'(instr_valid), 32'd0);
    tick();
    check("c1_valid", 32'(instr_valid), 32'd0);
    check("c1_addr", imem_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("str%0d_valid", k), 32'(instr_valid), 32'd1);
      check($sformatf("str%0d_pc", k), instr_pc, 32'(4 * k));
      check($sformatf("str%0d_instr", k), instruction, 32'(4 * k) ^ 32'h13);
    end

    // Backpressure from startup.
    tick();
    reset = 1'b1; dec_ready = 1'b0;
    #1;
    check("bprst_req", 32'(imem_req), 32'd0);
    tick();
    reset = 1'b0;
    req_log.delete();
    repeat (10) tick();
    check("bp_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp_req%0d", i), (i < req_log.size()) ? req_log[i] : 32'hxxxx_xxxx, 32'(4 * i));
    check("bp_req_idle", 32'(imem_req), 32'd0);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_head_pc", instr_pc, 32'h0);
    check("bp_head_instr", instruction, 32'h13);

    req_log.delete();
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    repeat (4) tick();
    check("pulse_nreq", 32'(req_log.size()), 32'd1);
    check("pulse_req", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h10);
    check("pulse_head_pc", instr_pc, 32'h4);
    check("pulse_head_instr", instruction, 32'h17);

    // Redirect with a stale response in flight: FIFO 8..20, then pop and refetch 24.
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    repeat (4) tick();
    check("rd_head_pc", instr_pc, 32'h8);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("rd_refetch_addr", imem_addr, 32'h18);
    check("rd_refetch_req", 32'(imem_req), 32'd1);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check("rdR_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0; dec_ready = 1'b1;
    dec_pc_log.delete(); dec_instr_log.delete();
    #1;
    check_empty("rdR1");
    check("rdR1_req", 32'(imem_req), 32'd1);
    check("rdR1_addr", imem_addr, 32'h100);
    tick();
    check("rdR2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("rdR3_valid", 32'(instr_valid), 32'd1);
    check("rdR3_pc", instr_pc, 32'h100);
    check("rdR3_instr", instruction, 32'h113);
    tick();
    check("rd_first_dec_pc", (dec_pc_log.size() > 0) ? dec_pc_log[0] : 32'hxxxx_xxxx, 32'h100);

    // Wrap across 2^32.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    dec_pc_log.delete(); dec_instr_log.delete();
    for (int n = 0; n < 20 && dec_pc_log.size() < 4; n++) tick();
    check("wrap_count_ok", 32'(dec_pc_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap%0d_pc", i), (i < dec_pc_log.size()) ? dec_pc_log[i] : 32'hxxxx_xxxx, wrap_pc[i]);
      check($sformatf("wrap%0d_instr", i), (i < dec_instr_log.size()) ? dec_instr_log[i] : 32'hxxxx_xxxx, wrap_ins[i]);
    end

    // Reset with 3 entries queued and a request in flight.
    redirect_valid = 1'b1; redirect_pc = 32'h200; dec_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    check("mr_pre_pc", instr_pc, 32'h200);
    check("mr_pre_req", 32'(imem_req), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_empty("mr_c0");
    check("mr_c0_req", 32'(imem_req), 32'd1);
    check("mr_c0_addr", imem_addr, 32'h0);
    tick();
    check("mr_c1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("mr_c2_valid", 32'(instr_valid), 32'd1);
    check("mr_c2_pc", instr_pc, 32'h0);
    check("mr_c2_instr", instruction, 32'h13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
